// File: rtl/mfc_display_pkg.sv
// Shared constants for the clock display path.
//   - Active-low 7-segment codes {g,f,e,d,c,b,a} for 0-9, dash and all-off.
//   - Digit index coding shared with the set-mode cursor (0 = rightmost).
//   - Anode pattern with every digit dark.
//   - time_digits_t bundles the four BCD digits held for one frame.
package mfc_display_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [1:0] DIG_SEC01 = 2'd0;
  localparam logic [1:0] DIG_SEC10 = 2'd1;
  localparam logic [1:0] DIG_MIN01 = 2'd2;
  localparam logic [1:0] DIG_MIN10 = 2'd3;

  localparam logic [3:0] ANODE_OFF = 4'hF;

  typedef struct packed {
    logic [3:0] min10;
    logic [3:0] min01;
    logic [3:0] sec10;
    logic [3:0] sec01;
  } time_digits_t;

endpackage

// File: rtl/seg_display_driver_if.sv
// Digit interface between the clock datapath and the display driver.
//   min10/min01/sec10/sec01 : BCD time digits
//   blink_enable            : set mode active, selected digit blinks
//   blink_index             : digit to blink, coded like DIG_* in mfc_display_pkg
// master = datapath (drives), slave = display driver (consumes).
interface seg_display_driver_if;
  logic [3:0] min10;
  logic [3:0] min01;
  logic [3:0] sec10;
  logic [3:0] sec01;
  logic       blink_enable;
  logic [1:0] blink_index;

  modport master (output min10, min01, sec10, sec01, blink_enable, blink_index);
  modport slave  (input  min10, min01, sec10, sec01, blink_enable, blink_index);
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
//   bcd : 4-bit digit value
//   seg : active-low segments {g,f,e,d,c,b,a}; values above 9 show a dash
module bcd_to_seg
  import mfc_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   MCLK   : board clock
//   RESET  : synchronous, active-low reset
//   dig    : digit interface (slave) - BCD time digits and set-mode cursor
//   ANODE  : active-low digit enables, bit 0 = rightmost digit
//   SEG    : active-low segments {g,f,e,d,c,b,a}
//   DP     : active-low decimal point, lit on digit 2 as the min:sec separator
// Inputs are sampled once per frame (when the scan wraps from digit 3 to 0)
// so a frame never shows a mix of old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digit 3 when min10 is 0.
module seg_display_driver
  import mfc_display_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  MCLK,
  input  logic                  RESET,
  seg_display_driver_if.slave   dig,
  output logic [3:0]            ANODE,
  output logic [6:0]            SEG,
  output logic                  DP
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
  logic [1:0]         idx_q,         idx_d;
  time_digits_t       shadow_q,      shadow_d;
  logic               sh_en_q,       sh_en_d;
  logic [1:0]         sh_idx_q,      sh_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [3:0]         anode_q,       anode_d;
  logic [6:0]         seg_q,         seg_d;
  logic               dp_q,          dp_d;

  logic       scan_tc;
  logic       frame_wrap;
  logic       blink_tc;
  logic [3:0] cur_digit;
  logic [6:0] dec_seg;

  bcd_to_seg u_bcd_to_seg (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    scan_cnt_d    = scan_cnt_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    sh_en_d       = sh_en_q;
    sh_idx_d      = sh_idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    cur_digit     = shadow_q.sec01;

    scan_tc    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    frame_wrap = scan_tc && (idx_q == DIG_MIN10);
    blink_tc   = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

    // Scan timing: each digit is held for SCAN_DIV cycles.
    if (scan_tc) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end

    // Capture a coherent snapshot of the inputs at the frame boundary.
    if (frame_wrap) begin
      shadow_d = '{min10: dig.min10, min01: dig.min01,
                   sec10: dig.sec10, sec01: dig.sec01};
      sh_en_d  = dig.blink_enable;
      sh_idx_d = dig.blink_index;
    end

    // Blink timer runs only while the captured enable is set, so the first
    // blank half-period starts a full BLINK_DIV after enable is captured.
    if (!sh_en_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_tc) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + 1'b1;
    end

    unique case (idx_q)
      DIG_SEC01: cur_digit = shadow_q.sec01;
      DIG_SEC10: cur_digit = shadow_q.sec10;
      DIG_MIN01: cur_digit = shadow_q.min01;
      DIG_MIN10: cur_digit = shadow_q.min10;
      default:   cur_digit = shadow_q.sec01;
    endcase

    seg_d = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q == DIG_MIN10) && (shadow_q.min10 == 4'd0)) begin
      seg_d = SEG_OFF;
    end
`endif
    if (sh_en_q && blink_phase_q && (idx_q == sh_idx_q)) begin
      seg_d = SEG_OFF;
    end

    anode_d = ~(4'b0001 << idx_q);
    dp_d    = (idx_q != DIG_MIN01);
  end

  always_ff @(posedge MCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!RESET) begin
      scan_cnt_q    <= '0;
      idx_q         <= 2'd0;
      shadow_q      <= '0;
      sh_en_q       <= 1'b0;
      sh_idx_q      <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      anode_q       <= ANODE_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      sh_en_q       <= sh_en_d;
      sh_idx_q      <= sh_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign ANODE = anode_q;
  assign SEG   = seg_q;
  assign DP    = dp_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver with SCAN_DIV=4, BLINK_DIV=16.
// One frame = 16 cycles; checks are frame-aligned after each reset release.
module tb_seg_display_driver;
  import mfc_display_pkg::*;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ3 = 7'h7F;
`else
  localparam logic [6:0] LZ3 = 7'h40;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  seg_display_driver_if dif ();

  seg_display_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .MCLK  (clk),
    .RESET (rst_n),
    .dig   (dif),
    .ANODE (anode),
    .SEG   (seg),
    .DP    (dp)
  );

  typedef struct {
    string      name;
    logic [3:0] m10, m01, s10, s01;
    logic [27:0] exp;  // {digit3, digit2, digit1, digit0} segment codes
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  logic        pend_valid = 1'b0;
  logic [15:0] pend_digs;
  logic        pend_en;
  logic [1:0]  pend_idx;

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got ANODE=%h SEG=%h DP=%b, expected ANODE=%h SEG=%h DP=%b",
               name, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pending(input logic [15:0] digs, input logic en, input logic [1:0] idx);
    pend_digs  = digs;
    pend_en    = en;
    pend_idx   = idx;
    pend_valid = 1'b1;
  endtask

  // Walk nsteps cycles of a frame, checking the scanned digit each cycle;
  // pending inputs are driven two cycles into the frame (mid-frame).
  task automatic check_frame(input string name, input logic [27:0] exp, input int nsteps);
    for (int k = 0; k < nsteps; k++) begin
      int d;
      logic [3:0] ea;
      step();
      d  = k / 4;
      ea = ~(4'b0001 << d);
      check($sformatf("%s c%0d", name, k), {anode, seg, dp},
            {ea, exp[d*7 +: 7], (d != 2)});
      if (k == 1 && pend_valid) begin
        {dif.min10, dif.min01, dif.sec10, dif.sec01} = pend_digs;
        dif.blink_enable = pend_en;
        dif.blink_index  = pend_idx;
        pend_valid = 1'b0;
      end
    end
  endtask

  vec_t        vecs[5];
  logic [27:0] prev_exp;
  logic [27:0] exp_1234;
  logic [27:0] exp_12b4;
  logic [27:0] exp_zero;

  initial begin
    vecs[0] = '{"t1234",  4'h1, 4'h2, 4'h3, 4'h4, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{"bad_s10", 4'h1, 4'h2, 4'hC, 4'h4, {7'h79, 7'h24, 7'h3F, 7'h19}};
    vecs[2] = '{"t9876",  4'h9, 4'h8, 4'h7, 4'h6, {7'h10, 7'h00, 7'h78, 7'h02}};
    vecs[3] = '{"dashes", 4'hA, 4'hF, 4'h0, 4'hB, {7'h3F, 7'h3F, 7'h40, 7'h3F}};
    vecs[4] = '{"t0500",  4'h0, 4'h5, 4'h0, 4'h0, {LZ3,   7'h12, 7'h40, 7'h40}};
    exp_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    exp_12b4 = {7'h79, 7'h7F, 7'h30, 7'h19};
    exp_zero = {LZ3, 7'h40, 7'h40, 7'h40};

    rst_n = 1'b0;
    {dif.min10, dif.min01, dif.sec10, dif.sec01} = 16'h0000;
    dif.blink_enable = 1'b0;
    dif.blink_index  = 2'd0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset c%0d", i), {anode, seg, dp}, {4'hF, 7'h7F, 1'b1});
    end
    rst_n = 1'b1;
    check_frame("frame0", exp_zero, 16);
    prev_exp = exp_zero;

    // Table: apply mid-frame, old frame must finish untouched, next shows new.
    foreach (vecs[i]) begin
      set_pending({vecs[i].m10, vecs[i].m01, vecs[i].s10, vecs[i].s01}, 1'b0, 2'd0);
      check_frame({vecs[i].name, "_old"}, prev_exp, 16);
      check_frame({vecs[i].name, "_new"}, vecs[i].exp, 16);
      prev_exp = vecs[i].exp;
    end

    // Blink digit 2 at 12:34: normal frame, blank frame, alternating.
    set_pending(16'h1234, 1'b1, 2'd2);
    check_frame("blk_old", prev_exp, 16);
    check_frame("blk_on0", exp_1234, 16);
    check_frame("blk_off0", exp_12b4, 16);
    check_frame("blk_on1", exp_1234, 16);
    check_frame("blk_off1", exp_12b4, 10);  // stops while digit 2 is blank

    // Reset in the middle of a blank phase.
    rst_n = 1'b0;
    step();
    check("rst_mid c0", {anode, seg, dp}, {4'hF, 7'h7F, 1'b1});
    step();
    check("rst_mid c1", {anode, seg, dp}, {4'hF, 7'h7F, 1'b1});
    rst_n = 1'b1;
    check_frame("post_rst0", exp_zero, 16);
    check_frame("post_rst1", exp_1234, 16);
    check_frame("post_rst2", exp_12b4, 16);

    // Disable blinking.
    set_pending(16'h1234, 1'b0, 2'd2);
    check_frame("blk_dis0", exp_1234, 16);
    check_frame("blk_dis1", exp_1234, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
Consumer end of the clock datapath's digit interface. Takes the four BCD time digits (min10, min01, sec10, sec01) and the set-mode cursor (location/blink), then drives a 4-digit common-anode 7-segment display by time-multiplexed scanning. The selected digit blinks while set mode is active. It sits directly under the clock top and drives the board ANODE/SEG/DP pins.

Parameters:
SCAN_DIV, 100000, MCLK cycles each digit is lit (1 kHz per digit at 100 MHz).
BLINK_DIV, 25000000, MCLK cycles per blink half-period (2 Hz toggle at 100 MHz).

Ports:
MCLK  input  1  board clock; only clock in the block.
RESET  input  1  synchronous, active-low reset.
min10  input  4  BCD tens of minutes.
min01  input  4  BCD units of minutes.
sec10  input  4  BCD tens of seconds.
sec01  input  4  BCD units of seconds.
blink_enable  input  1  high in clock/alarm set mode; enables blinking.
blink_index  input  2  digit to blink: 0=sec01, 1=sec10, 2=min01, 3=min10 (same coding as location).
ANODE  output  4  active-low digit enables; bit n = digit n, bit 0 rightmost.
SEG  output  7  active-low segments {g,f,e,d,c,b,a}.
DP  output  1  active-low decimal point.

Behaviour:
- The reset is synchronous and active-low. On an MCLK edge with RESET=0: ANODE=4'b1111, SEG=7'h7F, DP=1. Also scan_cnt=0, idx=0, blink_cnt=0, blink_phase=0, and the shadow digits and shadow index are cleared to 0. Reset overrides everything, including mid-frame.
- Scan: scan_cnt counts 0..SCAN_DIV-1. At the terminal count it returns to 0 and idx advances 0→1→2→3→0.
- Outputs are registered from idx and the shadows, so they lag idx by one cycle. Exactly one ANODE bit is low at any time after the first post-reset edge, and each digit is lit for SCAN_DIV cycles.
- Frame capture: on the edge where idx wraps 3→0, all four digits, blink_enable and blink_index are copied into shadow registers. Display latency for an input change is at most 4*SCAN_DIV+1 cycles. Digits never tear within a frame.
- The first frame after reset shows 0000 with no blinking.
- Decode: values 0-9 map to 40,79,24,30,19,12,02,78,00,10 (hex). Values 10-15 show a dash (7'h3F).
- DP is 0 (lit) only while digit 2 is selected; it serves as the min:sec separator.
- Blink counter: while the shadow blink_enable is 0, blink_cnt and blink_phase are held at 0. Otherwise blink_cnt counts 0..BLINK_DIV-1, and blink_phase toggles at the terminal count. The first blank period therefore starts BLINK_DIV cycles after enable is captured.
- Blanking: when shadow blink_enable=1, blink_phase=1 and the selected digit equals the shadow blink_index, SEG=7'h7F. ANODE still scans normally, and DP is unaffected.
- A change of blink_index takes effect at the next frame boundary. Blink phase is not reset by an index change.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: when the shadow min10==0, digit 3 shows SEG=7'h7F. Blink rules still apply, so the result is blank either way.
- Undefined: digit 3 shows "0" as normal.

Decomposition:
- Shared package mfc_display_pkg holds:
  - the segment constants SEG_0..SEG_9, SEG_DASH=7'h3F and SEG_OFF=7'h7F;
  - the digit index constants DIG_SEC01=0, DIG_SEC10=1, DIG_MIN01=2, DIG_MIN10=3;
  - ANODE_OFF=4'hF.
- One natural sub-module, bcd_to_seg: purely combinational 4-bit to 7-bit active-low decode, with dash for values above 9.
- The scan counter, blink counter and shadows stay in the top of this block.

Test Plan:
Bench settings: SCAN_DIV=4, BLINK_DIV=16 for all scenarios.
1. Reset: hold RESET=0 for 3 cycles → ANODE=F, SEG=7F, DP=1. Release → ANODE cycles E,D,B,7, 4 cycles each, with SEG=40 on every digit in the first frame.
2. Digits 1,2,3,4 (min10..sec01) applied mid-frame → unchanged until the wrap, then the next frame shows ANODE E/SEG 19, D/30, B/24 with DP=0, then 7/79.
3. Invalid digit: sec10=4'hC → digit 1 shows SEG=3F in the following frame.
4. Blink: blink_enable=1, blink_index=2, time 12:34 → digit 2 shows 24 for 16 cycles after capture, then 7F for 16, alternating. Other digits are unaffected, and DP on digit 2 stays 0.
5. Reset mid-blink: RESET=0 during a blank phase → next edge gives ANODE=F, SEG=7F. After release, no blinking occurs until a frame wrap has captured enable and BLINK_DIV further cycles have elapsed.
6. LEADING_ZERO_BLANK_EN defined, time 05:00 → digit 3 shows 7F. Without the macro → digit 3 shows 40.
